// File: rtl/disp_pkg.sv
// Shared constants for the display read-data buffer: AXI data width,
// pixel width, default burst length and the bit offsets of the two
// 24-bit pixels packed in each 64-bit beat.
package disp_pkg;

  localparam int PIX_W         = 24;
  localparam int AXI_DW        = 64;
  localparam int DEF_BURST_LEN = 8;
  localparam int PIX0_LSB      = 0;
  localparam int PIX1_LSB      = 32;

  // Select one of the two pixels packed in a stored beat.
  function automatic logic [PIX_W-1:0] unpack_pix(input logic [AXI_DW-1:0] word,
                                                   input logic             sel);
    return sel ? word[PIX1_LSB +: PIX_W] : word[PIX0_LSB +: PIX_W];
  endfunction

endpackage

// File: rtl/disp_rdbuf_mem.sv
// DEPTH x 64-bit register array for the display read buffer.
// One synchronous write port, one asynchronous read port (head word).
module disp_rdbuf_mem
  import disp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [AXI_DW-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [AXI_DW-1:0] o_rdata
);

  logic [AXI_DW-1:0] r_mem [DEPTH];

  // Store the incoming beat at the write pointer.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/disp_rdbuf.sv
// Display read-data buffer: captures AXI read beats into a FIFO, reports
// spare room to the VRAM controller, and hands out 24-bit pixels (two per
// stored beat) with one cycle of latency.
// Optional build macro DISP_RDBUF_LEVEL_EN adds BUF_LEVEL and BURST_ERR.
module disp_rdbuf
  import disp_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [AXI_DW-1:0] RDATA,
  input  logic              RVALID,
  input  logic              RREADY,
  input  logic              RLAST,
  input  logic              DISPON,
  output logic              BUF_WREADY,
  input  logic              PIX_RE,
  output logic [PIX_W-1:0]  PIX_DATA,
  output logic              PIX_VALID,
  output logic              UNDERFLOW,
  output logic              OVERFLOW
`ifdef DISP_RDBUF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] BUF_LEVEL,
  output logic                   BURST_ERR
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_hsel;
  logic              r_wready;
  logic [PIX_W-1:0]  r_pix_data;
  logic              r_pix_valid;
  logic              r_underflow;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_beat;
  logic              w_push;
  logic              w_ovf;
  logic              w_req;
  logic              w_rd;
  logic              w_udf;
  logic              w_pop;
  logic              w_we;
  logic [CW-1:0]     w_count_next;
  logic [CW-1:0]     w_room;
  logic              w_wready_next;
  logic [AXI_DW-1:0] w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A beat is only accepted when the controller actually completes the
  // handshake and the display is on; a full buffer drops it.
  assign w_beat = RVALID & RREADY & DISPON;
  assign w_push = w_beat & ~w_full;
  assign w_ovf  = w_beat & w_full;

  // Each request consumes one half-word; the word is retired after its
  // upper pixel has been handed out.
  assign w_req = PIX_RE & DISPON;
  assign w_rd  = w_req & ~w_empty;
  assign w_udf = w_req & w_empty;
  assign w_pop = w_rd & r_hsel;

  // Storage is not written while reset is held, so beats of an
  // interrupted burst never land in the array.
  assign w_we = w_push & ~ARST;

  // Next occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Two bursts of headroom: one may already be in flight when the
  // controller samples the flag at RLAST.
  assign w_room        = CW'(DEPTH) - w_count_next;
  assign w_wready_next = DISPON & (w_room >= CW'(2 * BURST_LEN));

  disp_rdbuf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (ACLK),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (RDATA),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  // Pointer, occupancy, half-select and room flag; display-off flushes.
  always_ff @(posedge ACLK) begin
    if (ARST || !DISPON) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_hsel   <= 1'b0;
      r_wready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_rd) begin
        r_hsel <= ~r_hsel;
      end
      r_count  <= w_count_next;
      r_wready <= w_wready_next;
    end
  end

  // Pixel output: one-cycle latency, zeroed on an empty request, held
  // when nothing is requested.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
    end else if (!DISPON) begin
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= w_rd;
      if (w_rd) begin
        r_pix_data <= unpack_pix(w_head, r_hsel);
      end else if (w_udf) begin
        r_pix_data <= '0;
      end
    end
  end

  // Sticky error flags, cleared by reset or display-off.
  always_ff @(posedge ACLK) begin
    if (ARST || !DISPON) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_udf) begin
        r_underflow <= 1'b1;
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign BUF_WREADY = r_wready;
  assign PIX_DATA   = r_pix_data;
  assign PIX_VALID  = r_pix_valid;
  assign UNDERFLOW  = r_underflow;
  assign OVERFLOW   = r_overflow;

`ifdef DISP_RDBUF_LEVEL_EN
  localparam int BW = $clog2(BURST_LEN) + 1;

  logic [BW-1:0] r_beat;
  logic          r_burst_err;

  // Beat index within the current burst; RLAST on any index other than
  // the final one marks a malformed burst.
  always_ff @(posedge ACLK) begin
    if (ARST || !DISPON) begin
      r_beat      <= '0;
      r_burst_err <= 1'b0;
    end else if (w_push) begin
      if (RLAST) begin
        if (r_beat != BW'(BURST_LEN - 1)) begin
          r_burst_err <= 1'b1;
        end
        r_beat <= '0;
      end else if (r_beat != '1) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign BUF_LEVEL = r_count;
  assign BURST_ERR = r_burst_err;
`else
  // RLAST only feeds the burst checker, which is not built here.
  logic w_unused_rlast;
  assign w_unused_rlast = RLAST;
`endif

endmodule

// File: tb/tb_disp_rdbuf.sv
// Self-checking bench for disp_rdbuf: a per-cycle vector table for the
// basic burst-in / pixel-out path, then hand-written sequences for fill
// level, wrap-around, display-off flush and reset mid-burst.
module tb_disp_rdbuf;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [63:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;
  logic        DISPON;
  logic        BUF_WREADY;
  logic        PIX_RE;
  logic [23:0] PIX_DATA;
  logic        PIX_VALID;
  logic        UNDERFLOW;
  logic        OVERFLOW;
`ifdef DISP_RDBUF_LEVEL_EN
  logic [6:0]  BUF_LEVEL;
  logic        BURST_ERR;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] BASE = 64'h00BB_BBBB_00AA_AAAA;

  always #5 ACLK = ~ACLK;

  disp_rdbuf #(.DEPTH(64), .BURST_LEN(8)) dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .RDATA      (RDATA),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .RLAST      (RLAST),
    .DISPON     (DISPON),
    .BUF_WREADY (BUF_WREADY),
    .PIX_RE     (PIX_RE),
    .PIX_DATA   (PIX_DATA),
    .PIX_VALID  (PIX_VALID),
    .UNDERFLOW  (UNDERFLOW),
    .OVERFLOW   (OVERFLOW)
`ifdef DISP_RDBUF_LEVEL_EN
    ,
    .BUF_LEVEL  (BUF_LEVEL),
    .BURST_ERR  (BURST_ERR)
`endif
  );

  typedef struct {
    logic        rv;
    logic        last;
    logic        re;
    logic [63:0] d;
    logic        ev;
    logic [23:0] ed;
    logic        ewr;
    logic        eudf;
    logic [6:0]  el;
  } vec_t;

  vec_t tbl[26];

  logic [63:0] q[$];
  logic        mh;

  function automatic vec_t mk(input logic rv, last, re, input logic [63:0] d,
                              input logic ev, input logic [23:0] ed,
                              input logic ewr, eudf, input logic [6:0] el);
    vec_t v;
    v.rv = rv; v.last = last; v.re = re; v.d = d;
    v.ev = ev; v.ed = ed; v.ewr = ewr; v.eudf = eudf; v.el = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock once, settle just after the edge.
  task automatic step(input logic rst, rv, dis, re, input logic [63:0] d, input logic last);
    ARST   = rst;
    RVALID = rv;
    RREADY = rv;
    DISPON = dis;
    PIX_RE = re;
    RDATA  = d;
    RLAST  = last;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    chk("rst_wready", BUF_WREADY, 1'b0);
    chk("rst_valid",  PIX_VALID,  1'b0);
    chk("rst_data",   PIX_DATA,   24'd0);
    chk("rst_udf",    UNDERFLOW,  1'b0);
    chk("rst_ovf",    OVERFLOW,   1'b0);
    q.delete();
    mh = 1'b0;
  endtask

  // Queue-based reference: one cycle with DISPON=1, checking the pixel path.
  task automatic mstep(input logic rv, input logic [63:0] d, input logic re);
    logic        ev;
    logic [23:0] ed;
    int          sz0;
    sz0 = q.size();
    ev  = 1'b0;
    ed  = 24'd0;
    if (re && sz0 > 0) begin
      ev = 1'b1;
      ed = mh ? q[0][55:32] : q[0][23:0];
      if (mh) void'(q.pop_front());
      mh = ~mh;
    end
    if (rv && sz0 < 64) q.push_back(d);
    step(1'b0, rv, 1'b1, re, d, 1'b0);
    chk("m_valid", PIX_VALID, ev);
    if (re) chk("m_data", PIX_DATA, ed);
  endtask

  function automatic logic [63:0] wd(input int i);
    logic [23:0] lo, hi;
    lo = 24'(i);
    hi = 24'h100000 + 24'(i);
    return {8'h00, hi, 8'h00, lo};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: idle, one 8-beat burst, 16 reads, one empty read.
    tbl[0] = mk(0, 0, 0, 64'd0, 0, 24'd0, 1, 0, 7'd0);
    for (int b = 0; b < 8; b++)
      tbl[1 + b] = mk(1, b == 7, 0, BASE + 64'(b), 0, 24'd0, 1, 0, 7'(b + 1));
    for (int k = 0; k < 16; k++)
      tbl[9 + k] = mk(0, 0, 1, 64'd0, 1,
                      (k % 2 == 1) ? 24'hBBBBBB : 24'hAAAAAA + 24'(k / 2),
                      1, 0, 7'(8 - (k + 1) / 2));
    tbl[25] = mk(0, 0, 1, 64'd0, 0, 24'd0, 1, 1, 7'd0);

    // Burst in, pixels out, underflow on the 17th request.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      step(1'b0, tbl[i].rv, 1'b1, tbl[i].re, tbl[i].d, tbl[i].last);
      chk($sformatf("v%0d_valid", i), PIX_VALID, tbl[i].ev);
      chk($sformatf("v%0d_data", i), PIX_DATA, tbl[i].ed);
      chk($sformatf("v%0d_wready", i), BUF_WREADY, tbl[i].ewr);
      chk($sformatf("v%0d_udf", i), UNDERFLOW, tbl[i].eudf);
`ifdef DISP_RDBUF_LEVEL_EN
      chk($sformatf("v%0d_level", i), BUF_LEVEL, tbl[i].el);
      chk($sformatf("v%0d_berr", i), BURST_ERR, 1'b0);
`endif
    end

    // Fill: room flag drops when count reaches 49, overflow only past 64.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 48; i++) step(1'b0, 1'b1, 1'b1, 1'b0, wd(i), (i % 8) == 7);
    chk("fill48_wready", BUF_WREADY, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, wd(48), 1'b0);
    chk("fill49_wready", BUF_WREADY, 1'b0);
    chk("fill49_ovf", OVERFLOW, 1'b0);
    for (int i = 49; i < 64; i++) step(1'b0, 1'b1, 1'b1, 1'b0, wd(i), 1'b0);
    chk("fill64_ovf", OVERFLOW, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, wd(99), 1'b0);
    chk("fill65_ovf", OVERFLOW, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0);
    chk("full_rd0", PIX_DATA, 24'h000000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("off_ovf_clr", OVERFLOW, 1'b0);
    chk("off_wready", BUF_WREADY, 1'b0);

    // Wrap-around and simultaneous push/pop against the queue reference.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 59; i++) mstep(1'b1, wd(i), 1'b0);
    for (int i = 0; i < 109; i++) mstep(1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 20; i++) mstep(1'b1, wd(59 + i), 1'b1);
    for (int i = 0; i < 64 && q.size() > 0; i++) mstep(1'b0, 64'd0, 1'b1);
    mstep(1'b0, 64'd0, 1'b1);
    chk("wrap_drained_udf", UNDERFLOW, 1'b1);

    // Display off mid-burst at count 20 flushes and clears flags.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0);
    chk("off_pre_udf", UNDERFLOW, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0, wd(i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, wd(20), 1'b0);
    chk("off_wready0", BUF_WREADY, 1'b0);
    chk("off_udf_clr", UNDERFLOW, 1'b0);
    chk("off_valid", PIX_VALID, 1'b0);
    for (int i = 21; i < 24; i++) step(1'b0, 1'b1, 1'b0, 1'b0, wd(i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    chk("on_wready", BUF_WREADY, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0);
    chk("on_empty_valid", PIX_VALID, 1'b0);
    chk("on_empty_udf", UNDERFLOW, 1'b1);

    // Reset in the middle of a burst discards it.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, wd(i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, wd(3), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, wd(4), 1'b0);
    chk("mid_rst_wready", BUF_WREADY, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    chk("post_rst_wready", BUF_WREADY, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0);
    chk("post_rst_udf", UNDERFLOW, 1'b1);
    chk("post_rst_valid", PIX_VALID, 1'b0);

`ifdef DISP_RDBUF_LEVEL_EN
    // Short burst: RLAST on beat index 6.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, wd(i), i == 6);
    chk("short_berr", BURST_ERR, 1'b1);
    chk("short_level", BUF_LEVEL, 7'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
